// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - console register addresses, RX FSM state encoding and baud helper
package console_pkg;

  localparam logic [15:0] ADRS_RCSR = 16'o177560;
  localparam logic [15:0] ADRS_RBUF = 16'o177562;
  localparam logic [15:0] ADRS_XCSR = 16'o177564;
  localparam logic [15:0] ADRS_XBUF = 16'o177566;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_frq, input int baud_rate);
    return clk_frq / baud_rate;
  endfunction

endpackage

// File: rtl/console_rx_fifo_if.sv
// rtl/console_rx_fifo_if.sv - RBUF/RCSR side of the console receiver (CPU master, receiver slave)
interface console_rx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     rd_strobe;
  logic [7:0]               rbuf;
  logic                     rcsr_done;
  logic                     rx_overrun;
  logic                     rx_framing_err;
  logic                     rx_parity_err;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  modport master (
    output rd_strobe,
    input  rbuf, rcsr_done, rx_overrun, rx_framing_err, rx_parity_err, fifo_count
  );

  modport slave (
    input  rd_strobe,
    output rbuf, rcsr_done, rx_overrun, rx_framing_err, rx_parity_err, fifo_count
  );
endinterface

// File: rtl/rx_fifo_mem.sv
// rtl/rx_fifo_mem.sv - dual-pointer byte FIFO, register array with show-ahead read
module rx_fifo_mem #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  // A pop makes room for a push in the same cycle; a pop on empty is ignored.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
endmodule

// File: rtl/console_rx_fifo.sv
// rtl/console_rx_fifo.sv - buffered console UART receiver behind RCSR/RBUF
// Optional even-parity 11-bit frames when CONSOLE_RX_PARITY_EN is defined.
module console_rx_fifo
  import console_pkg::*;
#(
  parameter int CLK_FRQ         = 27_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  console_rx_fifo_if.slave bus
);
  localparam int          CPB     = clks_per_bit(CLK_FRQ, BAUD_RATE);
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);

  logic        sync1, sync2;
  rx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        push_q, push_nxt;
  logic        ferr_set;
  logic        ovr_q, ferr_q;
  logic [7:0]  head;
  logic        full, empty;
  logic [FIFO_DEPTH_LOG2:0] count;
`ifdef CONSOLE_RX_PARITY_EN
  logic        perr_set, perr_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      push_q  <= 1'b0;
    end else begin
      sync1   <= rx_in;
      sync2   <= sync1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      shift   <= shift_nxt;
      push_q  <= push_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    push_nxt  = 1'b0;
    ferr_set  = 1'b0;
`ifdef CONSOLE_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: if (!sync2) begin
        cnt_nxt   = HALF_M1;
        state_nxt = START;
      end
      // Mid-bit resample rejects line glitches shorter than half a bit.
      START: if (cnt != '0) cnt_nxt = cnt - 16'd1;
        else if (sync2) state_nxt = IDLE;
        else begin
          state_nxt = DATA;
          idx_nxt   = '0;
          cnt_nxt   = CPB_M1;
        end
      DATA: if (cnt != '0) cnt_nxt = cnt - 16'd1;
        else begin
          shift_nxt = {sync2, shift[7:1]};
          cnt_nxt   = CPB_M1;
          if (bit_idx == 3'd7) begin
`ifdef CONSOLE_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end
`ifdef CONSOLE_RX_PARITY_EN
      PARITY: if (cnt != '0) cnt_nxt = cnt - 16'd1;
        else begin
          perr_set  = (sync2 != ^shift);
          cnt_nxt   = CPB_M1;
          state_nxt = STOP;
        end
`endif
      STOP: if (cnt != '0) cnt_nxt = cnt - 16'd1;
        else if (sync2) begin
          push_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = BREAK;
        end
      BREAK: if (sync2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  rx_fifo_mem #(.AW(FIFO_DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_q),
    .wr_data (shift),
    .rd_en   (bus.rd_strobe),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (push_q && full && !bus.rd_strobe) ovr_q <= 1'b1;
      else if (bus.rd_strobe)               ovr_q <= 1'b0;
      if (ferr_set)           ferr_q <= 1'b1;
      else if (bus.rd_strobe) ferr_q <= 1'b0;
    end
  end

`ifdef CONSOLE_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           perr_q <= 1'b0;
    else if (perr_set)      perr_q <= 1'b1;
    else if (bus.rd_strobe) perr_q <= 1'b0;
  end
  assign bus.rx_parity_err = perr_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  assign bus.rbuf           = empty ? 8'h00 : head;
  assign bus.rcsr_done      = !empty;
  assign bus.rx_overrun     = ovr_q;
  assign bus.rx_framing_err = ferr_q;
  assign bus.fifo_count     = count;
endmodule

// File: tb/tb_console_rx_fifo.sv
// tb/tb_console_rx_fifo.sv - directed self-checking bench for console_rx_fifo
module tb_console_rx_fifo;
  localparam int CPB = 234;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_in = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t_done;

  console_rx_fifo_if #(.FIFO_DEPTH_LOG2(4)) bus ();

  console_rx_fifo #(
    .CLK_FRQ         (27_000_000),
    .BAUD_RATE       (115200),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_in   (rx_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bits(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input int stop_low);
    bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) bits(d[i], CPB);
`ifdef CONSOLE_RX_PARITY_EN
    bits(par, CPB);
`else
    if (par !== ^d) $display("[TB] note: parity bit ignored in this build");
`endif
    if (stop_low > 0) bits(1'b0, stop_low * CPB);
    bits(1'b1, CPB);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, ^d, 0);
  endtask

  task automatic pop();
    @(negedge clk) bus.rd_strobe = 1'b1;
    @(negedge clk) bus.rd_strobe = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rbuf"},  32'(bus.rbuf), 32'h0);
    chk({tag, "_done"},  32'(bus.rcsr_done), 32'h0);
    chk({tag, "_ovr"},   32'(bus.rx_overrun), 32'h0);
    chk({tag, "_ferr"},  32'(bus.rx_framing_err), 32'h0);
    chk({tag, "_perr"},  32'(bus.rx_parity_err), 32'h0);
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'h0);
  endtask

  initial begin
    bus.rd_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_all_zero("post_reset");

    // Test 1: single byte, rcsr_done rises shortly after the stop-bit midpoint
    fork
      send(8'h55);
      begin
        int c = 0;
        while (!bus.rcsr_done && c < 3000) begin
          @(negedge clk);
          c++;
        end
        t_done = c;
      end
    join
    chk("t1_done_window", 32'((t_done >= 9 * CPB + CPB / 2) && (t_done <= 10 * CPB)), 32'h1);
    chk("t1_rbuf", 32'(bus.rbuf), 32'h55);
    chk("t1_count", 32'(bus.fifo_count), 32'h1);
    pop();
    chk("t1_empty_after_pop", 32'(bus.rcsr_done), 32'h0);
    pop();
    chk("t1_pop_empty_ignored", 32'(bus.fifo_count), 32'h0);

    // Test 2: three back-to-back bytes, read out in order
    send(8'h41);
    send(8'h42);
    send(8'h43);
    chk("t2_count", 32'(bus.fifo_count), 32'h3);
    chk("t2_rbuf0", 32'(bus.rbuf), 32'h41);
    pop();
    repeat (10) @(negedge clk);
    chk("t2_rbuf1", 32'(bus.rbuf), 32'h42);
    pop();
    repeat (10) @(negedge clk);
    chk("t2_rbuf2", 32'(bus.rbuf), 32'h43);
    pop();
    chk("t2_done_low", 32'(bus.rcsr_done), 32'h0);
    chk("t2_rbuf_empty", 32'(bus.rbuf), 32'h0);

    // Test 3: overflow by one byte
    for (int i = 0; i < 17; i++) send(8'h60 + 8'(i));
    chk("t3_count_full", 32'(bus.fifo_count), 32'd16);
    chk("t3_overrun", 32'(bus.rx_overrun), 32'h1);
    chk("t3_head", 32'(bus.rbuf), 32'h60);
    pop();
    chk("t3_overrun_clr", 32'(bus.rx_overrun), 32'h0);
    chk("t3_count_15", 32'(bus.fifo_count), 32'd15);
    for (int i = 1; i < 16; i++) begin
      chk("t3_drain", 32'(bus.rbuf), 32'h60 + 32'(i));
      pop();
    end
    chk("t3_17th_absent", 32'(bus.rcsr_done), 32'h0);

    // Test 4: short glitch is rejected
    bits(1'b0, 50);
    bits(1'b1, 300);
    chk("t4_count", 32'(bus.fifo_count), 32'h0);
    chk("t4_done", 32'(bus.rcsr_done), 32'h0);
    chk("t4_fsm_idle", 32'(dut.state), 32'(console_pkg::IDLE));

    // Test 5: framing error followed by a good byte
    send_frame(8'h7E, ^8'h7E, 2);
    chk("t5_ferr", 32'(bus.rx_framing_err), 32'h1);
    chk("t5_nothing_queued", 32'(bus.fifo_count), 32'h0);
    send(8'h0D);
    chk("t5_rbuf", 32'(bus.rbuf), 32'h0D);
    chk("t5_ferr_sticky", 32'(bus.rx_framing_err), 32'h1);
    pop();
    chk("t5_ferr_clr", 32'(bus.rx_framing_err), 32'h0);

    // Test 6: asynchronous reset in the middle of bit 4
    send(8'h11);
    send(8'h22);
    chk("t6_queued", 32'(bus.fifo_count), 32'h2);
    bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) bits(1'(8'h5A >> i), CPB);
    bits(1'b1, CPB / 2);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bits(1'b1, 12 * CPB);
    chk_all_zero("t6_after");
    send(8'h96);
    chk("t6_next_rbuf", 32'(bus.rbuf), 32'h96);
    chk("t6_next_count", 32'(bus.fifo_count), 32'h1);
    pop();

`ifdef CONSOLE_RX_PARITY_EN
    // Parity build: wrong parity still queues the byte
    send_frame(8'h03, 1'b1, 0);
    chk("par_err", 32'(bus.rx_parity_err), 32'h1);
    chk("par_rbuf", 32'(bus.rbuf), 32'h03);
    pop();
    chk("par_err_clr", 32'(bus.rx_parity_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
